// File: rtl/msx_audio_decimator.sv
// Stereo audio output stage: one-pole low-pass at clock rate, fractional-N
// decimation to SAMPLE_RATE, DC blocker, and a valid/ready output register.
module msx_audio_decimator #(
  parameter int unsigned sysCLK      = 21477270,
  parameter int unsigned SAMPLE_RATE = 48000,
  parameter int unsigned LP_SHIFT    = 6,
  parameter int unsigned DC_SHIFT    = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic signed [15:0] audio_L,
  input  logic signed [15:0] audio_R,
  input  logic               mute,
  output logic signed [15:0] out_L,
  output logic signed [15:0] out_R,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         overrun_cnt
);
  localparam int unsigned LP_W    = 16 + LP_SHIFT;
  localparam logic [32:0] PH_STEP = 33'(SAMPLE_RATE);
  localparam logic [32:0] PH_WRAP = 33'(sysCLK);

  function automatic logic signed [LP_W-1:0] lp_next(input logic signed [LP_W-1:0] lp,
                                                     input logic signed [15:0] x);
    return lp + LP_W'(x) - (lp >>> LP_SHIFT);
  endfunction

  function automatic logic signed [17:0] dc_next(input logic signed [15:0] s,
                                                 input logic signed [15:0] sp,
                                                 input logic signed [15:0] y);
    return 18'(s) - 18'(sp) + 18'(y) - 18'(y >>> DC_SHIFT);
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [17:0] d);
    if (d > 18'sd32767)       return 16'sh7fff;
    else if (d < -18'sd32768) return 16'sh8000;
    else                      return d[15:0];
  endfunction

  logic [31:0]            ph_p0;
  logic [32:0]            ph_sum;
  logic                   tick_p0;
  logic signed [LP_W-1:0] lp_l_p0, lp_r_p0;
  logic signed [15:0]     x_l, x_r, s_l, s_r;
  logic signed [15:0]     sp_l_p1, sp_r_p1, y_l_p1, y_r_p1;
  logic                   vld_p1;

  assign ph_sum = {1'b0, ph_p0} + PH_STEP;
  assign x_l    = mute ? 16'sh0 : audio_L;
  assign x_r    = mute ? 16'sh0 : audio_R;
  // lp holds value * 2^LP_SHIFT, so its top 16 bits are the filter output
  assign s_l    = lp_l_p0[LP_W-1 -: 16];
  assign s_r    = lp_r_p0[LP_W-1 -: 16];

  // Stage p0: phase accumulator tick and clock-rate low-pass
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph_p0   <= '0;
      tick_p0 <= 1'b0;
      lp_l_p0 <= '0;
      lp_r_p0 <= '0;
    end else begin
      if (ph_sum >= PH_WRAP) begin
        ph_p0   <= 32'(ph_sum - PH_WRAP);
        tick_p0 <= 1'b1;
      end else begin
        ph_p0   <= ph_sum[31:0];
        tick_p0 <= 1'b0;
      end
      lp_l_p0 <= lp_next(lp_l_p0, x_l);
      lp_r_p0 <= lp_next(lp_r_p0, x_r);
    end
  end

  // Stage p1: DC blocker, advanced once per output tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      sp_l_p1 <= '0;
      sp_r_p1 <= '0;
      y_l_p1  <= '0;
      y_r_p1  <= '0;
    end else begin
      vld_p1 <= tick_p0;
      if (tick_p0) begin
        sp_l_p1 <= s_l;
        sp_r_p1 <= s_r;
        y_l_p1  <= sat16(dc_next(s_l, sp_l_p1, y_l_p1));
        y_r_p1  <= sat16(dc_next(s_r, sp_r_p1, y_r_p1));
      end
    end
  end

  // Stage p2: output holding register; a held sample wins over a new one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_L       <= '0;
      out_R       <= '0;
      out_valid   <= 1'b0;
      overrun_cnt <= '0;
    end else if (vld_p1 && (!out_valid || out_ready)) begin
      out_L     <= y_l_p1;
      out_R     <= y_r_p1;
      out_valid <= 1'b1;
    end else if (vld_p1) begin
      if (overrun_cnt != 8'hff) overrun_cnt <= overrun_cnt + 8'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_msx_audio_decimator.sv
// Bench for msx_audio_decimator: three instances (main, saturation, fractional
// rate) with a behavioural model feeding a sample scoreboard.
module tb_msx_audio_decimator;
  typedef struct {
    longint ph, lpl, lpr;
    int     spl, spr, yl, yr, ovr;
    bit     tick, dcv, ov;
  } mstate_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic               rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
  logic signed [15:0] aud_l_a = '0, aud_r_a = '0, aud_l_b = '0, aud_l_c = '0;
  logic signed [15:0] zero16 = '0;
  logic               mute_a = 1'b0, mute_off = 1'b0;
  logic               rdy_a = 1'b1, rdy_b = 1'b1, rdy_c = 1'b1;
  logic signed [15:0] out_L_a, out_R_a, out_L_b, out_R_b, out_L_c, out_R_c;
  logic               out_valid_a, out_valid_b, out_valid_c;
  logic [7:0]         ovr_a, ovr_b, ovr_c;

  msx_audio_decimator #(.sysCLK(100), .SAMPLE_RATE(10), .LP_SHIFT(2), .DC_SHIFT(4)) dut_a (
    .clk(clk), .reset_n(rst_a), .audio_L(aud_l_a), .audio_R(aud_r_a), .mute(mute_a),
    .out_L(out_L_a), .out_R(out_R_a), .out_valid(out_valid_a), .out_ready(rdy_a),
    .overrun_cnt(ovr_a));

  msx_audio_decimator #(.sysCLK(100), .SAMPLE_RATE(10), .LP_SHIFT(0), .DC_SHIFT(4)) dut_b (
    .clk(clk), .reset_n(rst_b), .audio_L(aud_l_b), .audio_R(zero16), .mute(mute_off),
    .out_L(out_L_b), .out_R(out_R_b), .out_valid(out_valid_b), .out_ready(rdy_b),
    .overrun_cnt(ovr_b));

  msx_audio_decimator #(.sysCLK(1000), .SAMPLE_RATE(3)) dut_c (
    .clk(clk), .reset_n(rst_c), .audio_L(aud_l_c), .audio_R(zero16), .mute(mute_off),
    .out_L(out_L_c), .out_R(out_R_c), .out_valid(out_valid_c), .out_ready(rdy_c),
    .overrun_cnt(ovr_c));

  function automatic int clamp16(input int d);
    if (d > 32767)  return 32767;
    if (d < -32768) return -32768;
    return d;
  endfunction

  function automatic longint wrapw(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic mstate_t mzero();
    mstate_t z;
    z.ph = 0; z.lpl = 0; z.lpr = 0; z.spl = 0; z.spr = 0; z.yl = 0; z.yr = 0;
    z.ovr = 0; z.tick = 0; z.dcv = 0; z.ov = 0;
    return z;
  endfunction

  function automatic bit mpush(input mstate_t m, input bit rdy);
    return m.dcv && (!m.ov || rdy);
  endfunction

  function automatic mstate_t mstep(input mstate_t m, input longint sysclk, input longint srate,
                                    input int lps, input int dcs, input int al, input int ar,
                                    input bit mu, input bit rdy);
    mstate_t n;
    int sl, sr;
    longint xl, xr;
    n = m;
    if (mpush(m, rdy)) n.ov = 1'b1;
    else if (m.dcv) begin
      if (m.ovr < 255) n.ovr = m.ovr + 1;
    end else if (m.ov && rdy) n.ov = 1'b0;
    if (m.tick) begin
      sl = int'(m.lpl >>> lps);
      sr = int'(m.lpr >>> lps);
      n.spl = sl;
      n.spr = sr;
      n.yl = clamp16(sl - m.spl + m.yl - (m.yl >>> dcs));
      n.yr = clamp16(sr - m.spr + m.yr - (m.yr >>> dcs));
    end
    n.dcv = m.tick;
    if (m.ph + srate >= sysclk) begin
      n.ph = m.ph + srate - sysclk;
      n.tick = 1'b1;
    end else begin
      n.ph = m.ph + srate;
      n.tick = 1'b0;
    end
    xl = mu ? 0 : al;
    xr = mu ? 0 : ar;
    n.lpl = wrapw(m.lpl + xl - (m.lpl >>> lps), 16 + lps);
    n.lpr = wrapw(m.lpr + xr - (m.lpr >>> lps), 16 + lps);
    return n;
  endfunction

  mstate_t ma, mb;
  logic [31:0] qa[$], qb[$];

  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      ma <= mzero();
      qa.delete();
    end else begin
      if (mpush(ma, rdy_a)) qa.push_back({ma.yl[15:0], ma.yr[15:0]});
      ma <= mstep(ma, 100, 10, 2, 4, aud_l_a, aud_r_a, mute_a, rdy_a);
    end
  end

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mb <= mzero();
      qb.delete();
    end else begin
      if (mpush(mb, rdy_b)) qb.push_back({mb.yl[15:0], mb.yr[15:0]});
      mb <= mstep(mb, 100, 10, 0, 4, aud_l_b, 0, 1'b0, rdy_b);
    end
  end

  // Scoreboard: every accepted sample must match the next modelled sample
  always @(negedge clk) begin
    logic [31:0] exp_s;
    if (rst_a && out_valid_a && rdy_a) begin
      checks++;
      if (qa.size() == 0) begin
        failures++;
        $display("FAIL sb_a_empty: got %h with no expected sample queued", {out_L_a, out_R_a});
      end else begin
        exp_s = qa.pop_front();
        if ({out_L_a, out_R_a} !== exp_s) begin
          failures++;
          $display("FAIL sb_a_sample: got %h expected %h at %0t", {out_L_a, out_R_a}, exp_s, $time);
        end
      end
    end
    if (rst_b && out_valid_b && rdy_b) begin
      checks++;
      if (qb.size() == 0) begin
        failures++;
        $display("FAIL sb_b_empty: got %h with no expected sample queued", {out_L_b, out_R_b});
      end else begin
        exp_s = qb.pop_front();
        if ({out_L_b, out_R_b} !== exp_s) begin
          failures++;
          $display("FAIL sb_b_sample: got %h expected %h at %0t", {out_L_b, out_R_b}, exp_s, $time);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    int first, last, pulses, bad_gap, wide;
    bit prev;
    rst_a = 1'b0; aud_l_a = '0; aud_r_a = '0; mute_a = 1'b0; rdy_a = 1'b1;
    cyc(3);
    checks++; if (out_L_a !== 16'sh0) begin failures++; $display("FAIL rst_out_L: got %h expected 0000", out_L_a); end
    checks++; if (out_R_a !== 16'sh0) begin failures++; $display("FAIL rst_out_R: got %h expected 0000", out_R_a); end
    checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", out_valid_a); end
    checks++; if (ovr_a !== 8'd0) begin failures++; $display("FAIL rst_overrun: got %0d expected 0", ovr_a); end
    rst_a = 1'b1;
    first = -1; last = -1; pulses = 0; bad_gap = 0; wide = 0; prev = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      cyc(1);
      if (out_valid_a) begin
        if (first < 0) first = i;
        if (last >= 0 && i - last != 10) bad_gap++;
        if (prev) wide++;
        last = i;
        pulses++;
      end
      prev = out_valid_a;
    end
    checks++; if (first != 12) begin failures++; $display("FAIL idle_first_valid: got cycle %0d expected 12", first); end
    checks++; if (pulses != 5) begin failures++; $display("FAIL idle_pulse_count: got %0d expected 5", pulses); end
    checks++; if (bad_gap != 0) begin failures++; $display("FAIL idle_spacing: got %0d bad gaps expected 0", bad_gap); end
    checks++; if (wide != 0) begin failures++; $display("FAIL idle_pulse_width: got %0d wide pulses expected 0", wide); end
  endtask

  task automatic test_step();
    int lv[40];
    int n, rbad, nonmono;
    rst_a = 1'b0;
    cyc(1);
    aud_l_a = 16'sh4000; aud_r_a = '0;
    rst_a = 1'b1;
    n = 0; rbad = 0; nonmono = 0;
    for (int i = 0; i < 600 && n < 40; i++) begin
      cyc(1);
      if (out_valid_a) begin
        lv[n] = int'(out_L_a);
        if (out_R_a !== 16'sh0) rbad++;
        n++;
      end
    end
    checks++;
    if (n != 40) begin
      failures++; $display("FAIL step_timeout: got %0d samples expected 40", n);
    end else begin
      for (int k = 1; k < 40; k++) if (lv[k] > lv[k-1] || lv[k] < 0) nonmono++;
      checks++; if (lv[0] <= 0) begin failures++; $display("FAIL step_first_positive: got %0d expected > 0", lv[0]); end
      checks++; if (nonmono != 0) begin failures++; $display("FAIL step_monotonic: got %0d violations expected 0", nonmono); end
      checks++; if (lv[39] * 4 >= lv[0]) begin failures++; $display("FAIL step_decay: got %0d expected < %0d", lv[39], lv[0] / 4); end
      checks++; if (rbad != 0) begin failures++; $display("FAIL step_right_zero: got %0d nonzero R samples expected 0", rbad); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int unstable;
    rst_a = 1'b0;
    cyc(1);
    aud_l_a = 16'sh1234; aud_r_a = -16'sh0321; mute_a = 1'b0; rdy_a = 1'b1;
    rst_a = 1'b1;
    cyc(11);
    rdy_a = 1'b0;
    unstable = 0; held = '0;
    for (int k = 12; k <= 46; k++) begin
      cyc(1);
      if (k == 12) begin
        held = {out_L_a, out_R_a};
        checks++; if (out_valid_a !== 1'b1) begin failures++; $display("FAIL bp_first_load: got valid %b expected 1", out_valid_a); end
      end else if (!out_valid_a || {out_L_a, out_R_a} !== held) unstable++;
    end
    checks++; if (unstable != 0) begin failures++; $display("FAIL bp_hold_stable: got %0d changes expected 0", unstable); end
    checks++; if (ovr_a !== 8'd3) begin failures++; $display("FAIL bp_overrun3: got %0d expected 3", ovr_a); end
    rdy_a = 1'b1;
    cyc(1);
    checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL bp_single_accept: got valid %b expected 0", out_valid_a); end
    cyc(5);
    checks++; if (out_valid_a !== 1'b1) begin failures++; $display("FAIL bp_fresh_valid: got valid %b expected 1", out_valid_a); end
    checks++; if ({out_L_a, out_R_a} === held) begin failures++; $display("FAIL bp_fresh_data: got %h expected data other than %h", {out_L_a, out_R_a}, held); end
    cyc(1);
    rdy_a = 1'b0;
    cyc(30000);
    checks++; if (ovr_a !== 8'd255) begin failures++; $display("FAIL bp_overrun_sat: got %0d expected 255", ovr_a); end
    rdy_a = 1'b1;
    cyc(3);
  endtask

  task automatic test_saturation();
    int nmax, nmin, nsamp;
    aud_l_b = 16'sh7fff; rdy_b = 1'b1;
    rst_b = 1'b1;
    nmax = 0; nmin = 0; nsamp = 0;
    for (int p = 0; p < 4; p++) begin
      aud_l_b = (p % 2 == 0) ? 16'sh7fff : 16'sh8000;
      for (int i = 0; i < 1000; i++) begin
        cyc(1);
        if (out_valid_b) begin
          nsamp++;
          if (out_L_b === 16'sh7fff) nmax++;
          if (out_L_b === 16'sh8000) nmin++;
        end
      end
    end
    checks++; if (nsamp != 399) begin failures++; $display("FAIL sat_sample_count: got %0d expected 399", nsamp); end
    checks++; if (nmax != 2) begin failures++; $display("FAIL sat_clamp_max: got %0d samples of 7fff expected 2", nmax); end
    checks++; if (nmin != 2) begin failures++; $display("FAIL sat_clamp_min: got %0d samples of 8000 expected 2", nmin); end
  endtask

  task automatic test_fractional();
    int t[8];
    int np, badint;
    rdy_c = 1'b1;
    rst_c = 1'b1;
    np = 0; badint = 0;
    for (int i = 1; i <= 1600 && np < 4; i++) begin
      cyc(1);
      if (out_valid_c) begin
        t[np] = i;
        np++;
      end
    end
    checks++;
    if (np != 4) begin
      failures++; $display("FAIL frac_timeout: got %0d ticks expected 4", np);
    end else begin
      for (int k = 1; k < 4; k++) if (t[k] - t[k-1] != 333 && t[k] - t[k-1] != 334) badint++;
      checks++; if (t[0] != 336) begin failures++; $display("FAIL frac_first: got cycle %0d expected 336", t[0]); end
      checks++; if (badint != 0) begin failures++; $display("FAIL frac_spacing: got %0d bad intervals expected 0", badint); end
      checks++; if (t[3] - t[0] != 1000) begin failures++; $display("FAIL frac_three_per_1000: got span %0d expected 1000", t[3] - t[0]); end
    end
  endtask

  task automatic test_mute_reset();
    int nz, nsamp, vbad, waited;
    rst_a = 1'b0;
    cyc(1);
    mute_a = 1'b1; aud_l_a = 16'sh7000; aud_r_a = 16'sh7000; rdy_a = 1'b1;
    rst_a = 1'b1;
    nz = 0; nsamp = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(1);
      if (out_valid_a) begin
        nsamp++;
        if (out_L_a !== 16'sh0 || out_R_a !== 16'sh0) nz++;
      end
    end
    checks++; if (nsamp == 0 || nz != 0) begin failures++; $display("FAIL mute_zero: got %0d nonzero of %0d samples expected 0", nz, nsamp); end
    mute_a = 1'b0;
    cyc(100);
    checks++; if (out_L_a === 16'sh0) begin failures++; $display("FAIL unmute_nonzero: got %h expected nonzero", out_L_a); end
    waited = 0;
    while (!ma.tick && waited < 20) begin
      cyc(1);
      waited++;
    end
    checks++;
    if (!ma.tick) begin
      failures++; $display("FAIL mid_reset_tick_timeout: got no tick in %0d cycles expected one", waited);
    end else begin
      cyc(1);
      rst_a = 1'b0;
      #1;
      checks++; if (out_L_a !== 16'sh0) begin failures++; $display("FAIL mid_reset_out_L: got %h expected 0000", out_L_a); end
      checks++; if (out_R_a !== 16'sh0) begin failures++; $display("FAIL mid_reset_out_R: got %h expected 0000", out_R_a); end
      checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL mid_reset_valid: got %b expected 0", out_valid_a); end
      checks++; if (ovr_a !== 8'd0) begin failures++; $display("FAIL mid_reset_overrun: got %0d expected 0", ovr_a); end
      cyc(1);
      rst_a = 1'b1;
      vbad = 0;
      for (int i = 0; i < 8; i++) begin
        cyc(1);
        if (out_valid_a !== 1'b0) vbad++;
      end
      checks++; if (vbad != 0) begin failures++; $display("FAIL mid_reset_no_valid: got %0d valid cycles expected 0", vbad); end
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_backpressure();
    test_saturation();
    test_fractional();
    test_mute_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
